// File: rtl/psum_out_pkg.sv
// Shared constants for the psum AXI-Stream output buffer.
// Each buffered entry is {last, data}; the last flag sits above the data word.
package psum_out_pkg;

  localparam int PSUM_DATA_W  = 32;
  localparam int PSUM_ENTRY_W = PSUM_DATA_W + 1;
  localparam int PSUM_LAST_BIT = PSUM_DATA_W;

  // Data word carried by a terminator entry created for a lone layer-finish marker.
  localparam logic [PSUM_DATA_W-1:0] PSUM_TERM_DATA = '0;

endpackage

// File: rtl/psum_sync_fifo.sv
// Synchronous FIFO for {last, data} entries with push/pop/full/empty/count.
// A patch request sets the last bit of the newest stored entry (wr_ptr-1),
// which is how a lone layer-finish marker is folded into already-queued data.
module psum_sync_fifo
  import psum_out_pkg::*;
#(
  parameter int WIDTH    = PSUM_ENTRY_W,
  parameter int DEPTH    = 16,
  parameter int LAST_BIT = PSUM_LAST_BIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     patch_last,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count_q;
  logic [PW-1:0]    newest_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_CNT);
  assign count      = count_q;
  assign head       = mem[rd_ptr];
  assign newest_ptr = wr_ptr - 1'b1;

  // A push into a full FIFO is only legal when a pop frees a slot the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array: writes new entries, or marks the newest entry as layer-final.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end else if (patch_last && !empty) begin
      mem[newest_ptr][LAST_BIT] <= 1'b1;
    end
  end

endmodule

// File: rtl/psum_axis_out_buffer.sv
// AXI4-Stream output stage for packed psum words: output register plus FIFO,
// tlast guarantee for lone layer-finish markers, sticky overflow, frame_done pulse.
// Optional macro PSUM_AXIS_OUT_BEAT_CNT_EN adds per-frame beat counters.
module psum_axis_out_buffer
  import psum_out_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = PSUM_DATA_W,
  parameter int FIFO_DEPTH           = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic                             in_last,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]  in_data,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]  m_axis_tdata,
  output logic                             m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             overflow,
  output logic                             frame_done
`ifdef PSUM_AXIS_OUT_BEAT_CNT_EN
  ,
  output logic [15:0]                      beat_count,
  output logic [15:0]                      last_frame_beats
`endif
);

  localparam int ENTRY_W = C_M_AXIS_TDATA_WIDTH + 1;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  logic               hs;
  logic               out_free;
  logic               lone_last;
  logic               patch_fifo;
  logic               patch_out;
  logic               enq_term;
  logic               wr_req;
  logic [ENTRY_W-1:0] wr_entry;
  logic               bypass;
  logic               fifo_pop;
  logic               fifo_push;
  logic               drop;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ENTRY_W-1:0] load_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_cnt;

  assign hs        = m_axis_tvalid && m_axis_tready;
  assign out_free  = !m_axis_tvalid || hs;
  assign lone_last = in_last && !in_valid;

  // Lone marker: patch the newest unsent entry, or create a terminator if none is left.
  assign patch_fifo = lone_last && !fifo_empty;
  assign patch_out  = lone_last && fifo_empty && m_axis_tvalid && !hs;
  assign enq_term   = lone_last && fifo_empty && out_free;

  assign wr_req   = in_valid || enq_term;
  assign wr_entry = in_valid ? {in_last, in_data}
                             : {1'b1, C_M_AXIS_TDATA_WIDTH'(PSUM_TERM_DATA)};

  assign fifo_pop  = out_free && !fifo_empty;
  assign bypass    = wr_req && out_free && fifo_empty;
  assign fifo_push = wr_req && !bypass && (!fifo_full || fifo_pop);
  assign drop      = wr_req && !bypass && fifo_full && !fifo_pop;

  // If the entry being patched is also the one leaving the FIFO, fold the patch into the load.
  assign load_entry = (patch_fifo && (fifo_cnt == ONE_CNT))
                      ? (fifo_head | {1'b1, {C_M_AXIS_TDATA_WIDTH{1'b0}}})
                      : fifo_head;

  assign fifo_count = fifo_cnt;

  psum_sync_fifo #(
    .WIDTH    (ENTRY_W),
    .DEPTH    (FIFO_DEPTH),
    .LAST_BIT (C_M_AXIS_TDATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_data  (wr_entry),
    .pop        (fifo_pop),
    .patch_last (patch_fifo),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_cnt)
  );

  // Output register: reload from FIFO head or bypass when free; otherwise hold stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (out_free) begin
      if (fifo_pop) begin
        m_axis_tvalid                <= 1'b1;
        {m_axis_tlast, m_axis_tdata} <= load_entry;
      end else if (bypass) begin
        m_axis_tvalid                <= 1'b1;
        {m_axis_tlast, m_axis_tdata} <= wr_entry;
      end else begin
        m_axis_tvalid <= 1'b0;
      end
    end else if (patch_out) begin
      m_axis_tlast <= 1'b1;
    end
  end

  // Sticky overflow on any dropped word or terminator, and registered frame_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      frame_done <= hs && m_axis_tlast;
    end
  end

`ifdef PSUM_AXIS_OUT_BEAT_CNT_EN
  // Count handshaken beats per frame; the tlast beat closes the frame and records its total.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count       <= '0;
      last_frame_beats <= '0;
    end else if (hs) begin
      if (m_axis_tlast) begin
        beat_count       <= '0;
        last_frame_beats <= beat_count + 16'd1;
      end else begin
        beat_count <= beat_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_psum_axis_out_buffer.sv
// Self-checking bench for psum_axis_out_buffer: a queue model of all buffered
// entries is compared every cycle, plus directed scenarios with literal expectations.
module tb_psum_axis_out_buffer;

  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic         last;
    logic [W-1:0] data;
  } ent_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_last;
  logic [W-1:0]  in_data;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tlast;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          frame_done;
`ifdef PSUM_AXIS_OUT_BEAT_CNT_EN
  logic [15:0]   beat_count;
  logic [15:0]   last_frame_beats;
`endif

  int errors = 0;
  int checks = 0;

  ent_t mq[$];
  ent_t cap[$];
  int   fd_count;
  bit   model_live = 0;
  bit   m_ovf, m_fd, m_hs, m_term;
  int   m_beats, m_lastbeats;
  ent_t m_ent;

  psum_axis_out_buffer #(
    .C_M_AXIS_TDATA_WIDTH (W),
    .FIFO_DEPTH           (DEPTH)
  ) dut (
    .clk              (clk),
`ifdef PSUM_AXIS_OUT_BEAT_CNT_EN
    .beat_count       (beat_count),
    .last_frame_beats (last_frame_beats),
`endif
    .rst              (rst),
    .in_valid         (in_valid),
    .in_last          (in_last),
    .in_data          (in_data),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tlast     (m_axis_tlast),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .frame_done       (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison: counts it and reports a mismatch with actual and required values.
  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic applyStimulus(input logic v, input logic l, input logic [W-1:0] d,
                               input logic r);
    @(posedge clk);
    #1;
    in_valid      = v;
    in_last       = l;
    in_data       = d;
    m_axis_tready = r;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    m_axis_tready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Behavioural model: one queue holds everything buffered, front = beat on the bus.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf       = 1'b0;
      m_fd        = 1'b0;
      m_beats     = 0;
      m_lastbeats = 0;
      model_live  = 1'b1;
    end else if (model_live) begin
      m_hs   = (mq.size() > 0) && m_axis_tready;
      m_term = 1'b0;
      if (in_last && !in_valid) begin
        if (mq.size() > 1 || (mq.size() == 1 && !m_hs)) begin
          m_ent = mq.pop_back();
          m_ent.last = 1'b1;
          mq.push_back(m_ent);
        end else begin
          m_term = 1'b1;
        end
      end
      m_fd = 1'b0;
      if (m_hs) begin
        m_ent = mq.pop_front();
        m_fd  = m_ent.last;
        if (m_ent.last) begin
          m_lastbeats = m_beats + 1;
          m_beats     = 0;
        end else begin
          m_beats = m_beats + 1;
        end
      end
      if (in_valid || m_term) begin
        m_ent.last = in_valid ? in_last : 1'b1;
        m_ent.data = in_valid ? in_data : '0;
        if (mq.size() < DEPTH + 1) mq.push_back(m_ent);
        else m_ovf = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, plus capture of DUT handshakes.
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("tvalid", W'(m_axis_tvalid), W'(mq.size() > 0));
      if (mq.size() > 0) begin
        checkOutput("tdata", m_axis_tdata, mq[0].data);
        checkOutput("tlast", W'(m_axis_tlast), W'(mq[0].last));
      end
      checkOutput("fifo_count", W'(fifo_count), W'((mq.size() > 0) ? mq.size() - 1 : 0));
      checkOutput("overflow", W'(overflow), W'(m_ovf));
      checkOutput("frame_done", W'(frame_done), W'(m_fd));
`ifdef PSUM_AXIS_OUT_BEAT_CNT_EN
      checkOutput("beat_count", W'(beat_count), W'(m_beats));
      checkOutput("last_frame_beats", W'(last_frame_beats), W'(m_lastbeats));
`endif
    end
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      m_ent.last = m_axis_tlast;
      m_ent.data = m_axis_tdata;
      cap.push_back(m_ent);
    end
    if (frame_done === 1'b1) fd_count++;
  end

  // Bound on total run time so the bench always terminates.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_tvalid", W'(m_axis_tvalid), 0);
    checkOutput("rst_tdata", m_axis_tdata, 0);
    checkOutput("rst_tlast", W'(m_axis_tlast), 0);
    checkOutput("rst_count", W'(fifo_count), 0);
    checkOutput("rst_overflow", W'(overflow), 0);

    // Basic bypass with one cycle of latency
    cap.delete();
    fd_count = 0;
    applyStimulus(1, 0, 32'h11, 1);
    applyStimulus(1, 0, 32'h22, 1);
    @(negedge clk);
    checkOutput("bypass_latency_valid", W'(m_axis_tvalid), 1);
    checkOutput("bypass_latency_data", m_axis_tdata, 32'h11);
    applyStimulus(1, 1, 32'h33, 1);
    repeat (3) applyStimulus(0, 0, 0, 1);
    checkOutput("bypass_beats", W'(cap.size()), 3);
    if (cap.size() == 3) begin
      checkOutput("bypass_b0", {cap[0].last, cap[0].data[W-2:0]}, {1'b0, 31'h11});
      checkOutput("bypass_b1", {cap[1].last, cap[1].data[W-2:0]}, {1'b0, 31'h22});
      checkOutput("bypass_b2", {cap[2].last, cap[2].data[W-2:0]}, {1'b1, 31'h33});
    end
    checkOutput("bypass_frame_done", W'(fd_count), 1);

    // Backpressure fill, overflow, ordered drain
    doReset();
    cap.delete();
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 0, W'(i), 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("fill_count", W'(fifo_count), 16);
    checkOutput("fill_overflow", W'(overflow), 0);
    applyStimulus(1, 0, 32'h99, 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("ovf_set", W'(overflow), 1);
    checkOutput("ovf_count", W'(fifo_count), 16);
    repeat (20) applyStimulus(0, 0, 0, 1);
    checkOutput("drain_beats", W'(cap.size()), 17);
    for (int i = 0; i < cap.size() && i < 17; i++)
      checkOutput("drain_word", cap[i].data, W'(i));

    // Lone last patches the newest FIFO entry
    doReset();
    cap.delete();
    fd_count = 0;
    applyStimulus(1, 0, 32'hA, 0);
    applyStimulus(1, 0, 32'hB, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("patch_count", W'(fifo_count), 1);
    repeat (5) applyStimulus(0, 0, 0, 1);
    checkOutput("patch_beats", W'(cap.size()), 2);
    if (cap.size() == 2) begin
      checkOutput("patch_b0", {cap[0].last, cap[0].data[W-2:0]}, {1'b0, 31'hA});
      checkOutput("patch_b1", {cap[1].last, cap[1].data[W-2:0]}, {1'b1, 31'hB});
    end
    checkOutput("patch_frame_done", W'(fd_count), 1);

    // Lone last patches a word waiting in the output register
    applyStimulus(1, 0, 32'hC, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("patch_out_tlast", W'(m_axis_tlast), 1);
    checkOutput("patch_out_tdata", m_axis_tdata, 32'hC);
    repeat (3) applyStimulus(0, 0, 0, 1);

    // Lone last after a fully drained frame becomes a terminator beat
    cap.delete();
    fd_count = 0;
    applyStimulus(1, 1, 32'h5, 1);
    repeat (2) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 1);
    repeat (3) applyStimulus(0, 0, 0, 1);
    checkOutput("term_beats", W'(cap.size()), 2);
    if (cap.size() == 2) begin
      checkOutput("term_b0", {cap[0].last, cap[0].data[W-2:0]}, {1'b1, 31'h5});
      checkOutput("term_b1", {cap[1].last, cap[1].data[W-2:0]}, {1'b1, 31'h0});
    end
    checkOutput("term_frame_done", W'(fd_count), 2);

    // Full plus handshake: a push at full is accepted when a beat leaves
    doReset();
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 0, W'(i + 32'h100), 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("full_count", W'(fifo_count), 16);
    cap.delete();
    applyStimulus(1, 0, 32'h77, 1);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("fullhs_overflow", W'(overflow), 0);
    checkOutput("fullhs_count", W'(fifo_count), 16);
    repeat (20) applyStimulus(0, 0, 0, 1);
    checkOutput("fullhs_beats", W'(cap.size()), 18);
    if (cap.size() == 18) begin
      checkOutput("fullhs_first", cap[0].data, 32'h100);
      checkOutput("fullhs_last", cap[17].data, 32'h77);
    end

    // Reset mid-frame discards everything
    doReset();
    applyStimulus(1, 0, 32'h1, 1);
    applyStimulus(1, 0, 32'h2, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, W'(i + 32'h50), 0);
    applyStimulus(0, 0, 0, 0);
    doReset();
    @(negedge clk);
    checkOutput("midrst_tvalid", W'(m_axis_tvalid), 0);
    checkOutput("midrst_count", W'(fifo_count), 0);
`ifdef PSUM_AXIS_OUT_BEAT_CNT_EN
    checkOutput("midrst_beat_count", W'(beat_count), 0);
`endif
    applyStimulus(1, 0, 32'h42, 1);
    applyStimulus(0, 0, 0, 1);
    @(negedge clk);
    checkOutput("midrst_push_valid", W'(m_axis_tvalid), 1);
    checkOutput("midrst_push_data", m_axis_tdata, 32'h42);
    repeat (3) applyStimulus(0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
